// File: rtl/irrigation_pkg.sv
// Shared types and codes for the irrigation sequencer: FSM states, sensor
// bundle layout, and the level/mode digit codes seen by the display logic.
package irrigation_pkg;

    localparam int LEVEL_W = 2;
    localparam int MODE_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILL     = 3'd1,
        ST_SPRINKLE = 3'd2,
        ST_DRIP     = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    typedef struct packed {
        logic h;
        logic m;
        logic l;
        logic dry;
        logic rain;
    } sensors_t;

    localparam logic [LEVEL_W-1:0] LVL_EMPTY = 2'd0;
    localparam logic [LEVEL_W-1:0] LVL_LOW   = 2'd1;
    localparam logic [LEVEL_W-1:0] LVL_MID   = 2'd2;
    localparam logic [LEVEL_W-1:0] LVL_FULL  = 2'd3;

    localparam logic [MODE_W-1:0] MODE_IDLE     = 3'd0;
    localparam logic [MODE_W-1:0] MODE_FILL     = 3'd1;
    localparam logic [MODE_W-1:0] MODE_SPRINKLE = 3'd2;
    localparam logic [MODE_W-1:0] MODE_DRIP     = 3'd3;
    localparam logic [MODE_W-1:0] MODE_FAULT    = 3'd4;

    function automatic logic [MODE_W-1:0] mode_of(input state_t s);
        case (s)
            ST_FILL:     return MODE_FILL;
            ST_SPRINKLE: return MODE_SPRINKLE;
            ST_DRIP:     return MODE_DRIP;
            ST_FAULT:    return MODE_FAULT;
            default:     return MODE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/irrigation_sensor_filter.sv
// Synchronizes the raw sensor inputs and accepts a new sensor vector only after
// it has been seen unchanged on FILTER_TICKS consecutive ticks.
module irrigation_sensor_filter
    import irrigation_pkg::*;
#(
    parameter int FILTER_TICKS = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     tick,
    input  sensors_t raw,
    output sensors_t filtered,
    output logic     sensor_valid
);

    localparam int CNT_W = $clog2(FILTER_TICKS + 1);

    sensors_t               sync1;
    sensors_t               sync2;
    sensors_t               cand;
    logic [CNT_W-1:0]       stable_cnt;
    logic [CNT_W-1:0]       cnt_next;

    always_comb begin
        cnt_next = stable_cnt;
        if (sync2 != cand) begin
            cnt_next = CNT_W'(1);
        end else if (stable_cnt < CNT_W'(FILTER_TICKS)) begin
            cnt_next = stable_cnt + CNT_W'(1);
        end
    end

    // Filter history is wiped on reset so a full window is needed afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1        <= '0;
            sync2        <= '0;
            cand         <= '0;
            stable_cnt   <= '0;
            filtered     <= '0;
            sensor_valid <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (tick) begin
                cand       <= sync2;
                stable_cnt <= cnt_next;
                if (cnt_next == CNT_W'(FILTER_TICKS)) begin
                    filtered     <= sync2;
                    sensor_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/irrigation_sequencer.sv
// Irrigation mode controller: tick generation, filtered sensor decode, mode FSM,
// registered valve drives and display codes with a one-cycle update strobe.
module irrigation_sequencer
    import irrigation_pkg::*;
#(
    parameter int CLK_DIV       = 50000,
    parameter int FILTER_TICKS  = 4,
    parameter int MIN_RUN_TICKS = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               h,
    input  logic               m,
    input  logic               l,
    input  logic               dry,
    input  logic               rain,
    output logic               as_valve,
    output logic               gt_valve,
    output logic               fill_valve,
    output logic               alarm,
    output logic               disp_pulse,
    output logic [LEVEL_W-1:0] level_code,
    output logic [MODE_W-1:0]  mode_code
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int RUN_W = (MIN_RUN_TICKS < 1) ? 1 : $clog2(MIN_RUN_TICKS + 1);

    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    sensors_t           raw;
    sensors_t           filt;
    logic               sensor_valid;
    logic [LEVEL_W-1:0] level;
    logic               invalid;
    logic [RUN_W-1:0]   run_cnt;
    logic               run_done;
    logic               want_water;
    state_t             state;
    state_t             state_next;

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign raw  = {h, m, l, dry, rain};

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    irrigation_sensor_filter #(
        .FILTER_TICKS(FILTER_TICKS)
    ) u_filter (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .raw         (raw),
        .filtered    (filt),
        .sensor_valid(sensor_valid)
    );

    assign invalid    = (filt.h & ~filt.m) | (filt.m & ~filt.l);
    assign run_done   = (run_cnt >= RUN_W'(MIN_RUN_TICKS));
    assign want_water = filt.dry & ~filt.rain;

    always_comb begin
        if (!filt.l) begin
            level = LVL_EMPTY;
        end else if (!filt.m) begin
            level = LVL_LOW;
        end else if (!filt.h) begin
            level = LVL_MID;
        end else begin
            level = LVL_FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Faults and an empty tank preempt the minimum run time.
    always_comb begin
        state_next = state;
        if (tick && sensor_valid) begin
            if (invalid) begin
                state_next = ST_FAULT;
            end else if (state == ST_FAULT) begin
                state_next = ST_IDLE;
            end else if ((state == ST_SPRINKLE || state == ST_DRIP) && level == LVL_EMPTY) begin
                state_next = ST_FILL;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (level == LVL_EMPTY) begin
                            state_next = ST_FILL;
                        end else if (want_water) begin
                            state_next = (level == LVL_FULL) ? ST_SPRINKLE : ST_DRIP;
                        end
                    end
                    ST_FILL: begin
                        if (level == LVL_FULL) begin
                            state_next = ST_IDLE;
                        end
                    end
                    ST_SPRINKLE: begin
                        if (run_done) begin
                            if (!want_water) begin
                                state_next = ST_IDLE;
                            end else if (level != LVL_FULL) begin
                                state_next = ST_DRIP;
                            end
                        end
                    end
                    ST_DRIP: begin
                        if (run_done) begin
                            if (!want_water) begin
                                state_next = ST_IDLE;
                            end else if (level == LVL_FULL) begin
                                state_next = ST_SPRINKLE;
                            end
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt <= '0;
        end else if (state_next != state) begin
            run_cnt <= '0;
        end else if (tick && !run_done) begin
            run_cnt <= run_cnt + RUN_W'(1);
        end
    end

    // Valves decode the settled state; display codes capture the post-tick view.
    always_ff @(posedge clk) begin
        if (reset) begin
            as_valve   <= 1'b0;
            gt_valve   <= 1'b0;
            fill_valve <= 1'b0;
            alarm      <= 1'b0;
            disp_pulse <= 1'b0;
            level_code <= LVL_EMPTY;
            mode_code  <= MODE_IDLE;
        end else begin
            as_valve   <= (state == ST_SPRINKLE);
            gt_valve   <= (state == ST_DRIP);
            fill_valve <= (state == ST_FILL);
            alarm      <= (state == ST_FAULT);
            disp_pulse <= tick;
            if (tick) begin
                mode_code <= mode_of(state_next);
                if (!invalid) begin
                    level_code <= level;
                end
            end
        end
    end

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed scoreboard bench for irrigation_sequencer: each stimulus step queues
// the display codes expected at the following update strobe.
module tb_irrigation_sequencer;

    localparam int CLK_DIV       = 4;
    localparam int FILTER_TICKS  = 2;
    localparam int MIN_RUN_TICKS = 3;
    localparam int N_VEC         = 37;
    localparam int TMO           = 4 * CLK_DIV;

    // Sensor vectors, ordered {h, m, l, dry, rain}
    localparam logic [4:0] VA = 5'b11110;
    localparam logic [4:0] VB = 5'b01110;
    localparam logic [4:0] VC = 5'b00010;
    localparam logic [4:0] VD = 5'b11100;
    localparam logic [4:0] VE = 5'b10100;
    localparam logic [4:0] VF = 5'b11100;
    localparam logic [4:0] VG = 5'b01110;
    localparam logic [4:0] VH = 5'b01111;
    localparam logic [4:0] VI = 5'b00010;

    typedef struct packed {
        logic [1:0] lvl;
        logic [2:0] mode;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       h, m, l, dry, rain;
    logic       as_valve, gt_valve, fill_valve, alarm, disp_pulse;
    logic [1:0] level_code;
    logic [2:0] mode_code;

    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];
    exp_t       mon_exp;
    logic [9:0] tbl [N_VEC];

    irrigation_sequencer #(
        .CLK_DIV      (CLK_DIV),
        .FILTER_TICKS (FILTER_TICKS),
        .MIN_RUN_TICKS(MIN_RUN_TICKS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .h         (h),
        .m         (m),
        .l         (l),
        .dry       (dry),
        .rain      (rain),
        .as_valve  (as_valve),
        .gt_valve  (gt_valve),
        .fill_valve(fill_valve),
        .alarm     (alarm),
        .disp_pulse(disp_pulse),
        .level_code(level_code),
        .mode_code (mode_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Inputs for the next tick; the queued codes are those at that tick's strobe.
    task automatic apply(input int idx);
        {h, m, l, dry, rain} = tbl[idx][9:5];
        sb.push_back(tbl[idx][4:0]);
    endtask

    task automatic wait_disp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!disp_pulse && n < TMO);
        check("disp_pulse_seen", int'(disp_pulse), 1);
    endtask

    // Monitor: pops an expectation at every strobe, then checks valves a cycle later.
    initial begin
        forever begin
            @(negedge clk);
            if (disp_pulse) begin
                if (sb.size() == 0) begin
                    check("unexpected_disp_pulse", 1, 0);
                end else begin
                    mon_exp = sb.pop_front();
                    check("level_code", int'(level_code), int'(mon_exp.lvl));
                    check("mode_code", int'(mode_code), int'(mon_exp.mode));
                    @(negedge clk);
                    check("as_valve", int'(as_valve), int'(mon_exp.mode == 3'd2));
                    check("gt_valve", int'(gt_valve), int'(mon_exp.mode == 3'd3));
                    check("fill_valve", int'(fill_valve), int'(mon_exp.mode == 3'd1));
                    check("alarm", int'(alarm), int'(mon_exp.mode == 3'd4));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("valves_exclusive",
                  int'($countones({as_valve, gt_valve, fill_valve, alarm}) <= 1), 1);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl = '{
            {VA, 2'd0, 3'd0}, {VA, 2'd0, 3'd0}, {VA, 2'd3, 3'd2}, {VA, 2'd3, 3'd2},
            {VB, 2'd3, 3'd2}, {VB, 2'd3, 3'd2}, {VB, 2'd2, 3'd3},
            {VC, 2'd2, 3'd3}, {VC, 2'd2, 3'd3}, {VC, 2'd0, 3'd1},
            {VD, 2'd0, 3'd1}, {VD, 2'd0, 3'd1}, {VD, 2'd3, 3'd0},
            {VE, 2'd3, 3'd0}, {VE, 2'd3, 3'd0}, {VE, 2'd3, 3'd4},
            {VF, 2'd3, 3'd4}, {VF, 2'd3, 3'd4}, {VF, 2'd3, 3'd0},
            {VG, 2'd3, 3'd0}, {VG, 2'd3, 3'd0}, {VG, 2'd2, 3'd3},
            {VG, 2'd2, 3'd3}, {VG, 2'd2, 3'd3}, {VG, 2'd2, 3'd3},
            {VH, 2'd2, 3'd3}, {VG, 2'd2, 3'd3}, {VG, 2'd2, 3'd3},
            {VH, 2'd2, 3'd3}, {VH, 2'd2, 3'd3}, {VH, 2'd2, 3'd0},
            {VI, 2'd2, 3'd0}, {VI, 2'd2, 3'd0}, {VI, 2'd0, 3'd1},
            {VI, 2'd0, 3'd0}, {VI, 2'd0, 3'd0}, {VI, 2'd0, 3'd1}
        };

        reset = 1'b1;
        {h, m, l, dry, rain} = '0;
        repeat (3) @(negedge clk);
        check("rst_level_code", int'(level_code), 0);
        check("rst_mode_code", int'(mode_code), 0);
        check("rst_valves", int'({as_valve, gt_valve, fill_valve, alarm, disp_pulse}), 0);
        apply(0);
        reset = 1'b0;

        wait_disp(n);
        check("first_pulse_delay", n, CLK_DIV);
        for (int t = 1; t < 34; t++) begin
            apply(t);
            wait_disp(n);
        end

        // Now in FILL: reset mid-operation
        @(negedge clk);
        @(negedge clk);
        check("fill_before_reset", int'(fill_valve), 1);
        reset = 1'b1;
        @(negedge clk);
        check("fill_after_reset", int'(fill_valve), 0);
        check("valves_after_reset", int'({as_valve, gt_valve, alarm, disp_pulse}), 0);
        check("level_after_reset", int'(level_code), 0);
        check("mode_after_reset", int'(mode_code), 0);
        apply(34);
        reset = 1'b0;
        wait_disp(n);
        check("pulse_delay_after_reset", n, CLK_DIV);
        apply(35);
        wait_disp(n);
        apply(36);
        wait_disp(n);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irrigation_sequencer.md
Name: irrigation_sequencer

Overview:
Sequencing controller for the residential irrigation datapath. It samples the tank level sensors (h, m, l), soil-dry and rain inputs, and debounces them. It then runs the mode FSM (idle / fill / sprinkler / drip / fault) and drives the valves. It also generates the periodic update pulse and the registered level and mode digit codes that feed the display flip-flop set/clear decoding.

Parameters:
CLK_DIV, 50000, clock cycles per tick; legal range ≥2.
FILTER_TICKS, 4, consecutive identical ticks required before a sensor change is accepted; legal range ≥1.
MIN_RUN_TICKS, 10, minimum ticks spent in SPRINKLE or DRIP before a non-forced exit.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
h  input  1  tank level sensor, high (asynchronous to clk)
m  input  1  tank level sensor, medium (asynchronous)
l  input  1  tank level sensor, low (asynchronous)
dry  input  1  soil-dry sensor; 1 means irrigation is needed (asynchronous)
rain  input  1  rain sensor; 1 inhibits irrigation (asynchronous)
as_valve  output  1  sprinkler valve (As) open
gt_valve  output  1  drip valve (Gt) open
fill_valve  output  1  tank inlet valve open
alarm  output  1  sensor inconsistency fault
disp_pulse  output  1  one-cycle display update strobe
level_code  output  2  0 empty, 1 low, 2 mid, 3 full
mode_code  output  3  0 idle, 1 fill, 2 sprinkle, 3 drip, 4 fault

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. All logic is in the clk domain.
- Reset values: all outputs 0; state IDLE; all counters 0; filtered sensors 0; sensor_valid 0.
- Tick generator:
  - div_cnt counts 0..CLK_DIV-1 and wraps to 0.
  - tick is high for one cycle when div_cnt == CLK_DIV-1.
  - After reset, the first tick occurs in cycle CLK_DIV.
- Input path:
  - 2-FF synchronizer on {h,m,l,dry,rain}.
  - The filter compares the synced vector with a candidate register on each tick.
    - Equal: stable_cnt increments, saturating.
    - Different: the candidate is loaded and stable_cnt is set to 1.
  - When stable_cnt reaches FILTER_TICKS, the candidate is copied to the filtered vector and sensor_valid is set.
- Level decode (filtered):
  - l=0 → 0
  - l=1, m=0 → 1
  - m=1, h=0 → 2
  - h=1 → 3
  - invalid = (h & ~m) | (m & ~l). When invalid, level_code holds its previous value.
- FSM evaluates only on tick cycles and only when sensor_valid=1. Otherwise it holds. Transition priority is as listed, highest first:
  - Any state, invalid → FAULT. Forced; ignores the minimum run time.
  - FAULT, valid → IDLE.
  - SPRINKLE or DRIP, level 0 → FILL. Forced.
  - IDLE:
    - level 0 → FILL
    - dry & ~rain & level 3 → SPRINKLE
    - dry & ~rain & level 1 or 2 → DRIP
    - otherwise stay in IDLE.
  - FILL, level 3 → IDLE. Otherwise stay in FILL.
  - SPRINKLE, once run_cnt ≥ MIN_RUN_TICKS:
    - (~dry | rain) → IDLE
    - level < 3 → DRIP.
  - DRIP, once run_cnt ≥ MIN_RUN_TICKS:
    - (~dry | rain) → IDLE
    - level 3 → SPRINKLE.
- run_cnt:
  - Cleared on every state change.
  - Otherwise increments on tick, saturating at MIN_RUN_TICKS.
- Valve outputs:
  - Registered decode of the state: as_valve=SPRINKLE, gt_valve=DRIP, fill_valve=FILL, alarm=FAULT.
  - Outputs follow the state register by one cycle.
  - At most one valve is open in any cycle. Valve outputs must never be 1 simultaneously.
- Display:
  - disp_pulse asserts the cycle after each tick.
  - level_code and mode_code update in the same cycle as disp_pulse, reflecting the post-tick state.
  - Both are stable between pulses.
- Simultaneous events: a sensor change and a state transition on the same tick use the filtered values from before that tick. The new filtered value acts on the next tick.
- Reset mid-operation:
  - The valves close on the cycle after reset is sampled high.
  - Filter history is lost, so a full FILTER_TICKS window is needed before any valve can reopen.

Decomposition:
- Shared package irrigation_pkg:
  - state encoding (IDLE, FILL, SPRINKLE, DRIP, FAULT)
  - level codes
  - mode codes
  - code widths
- One sub-module, irrigation_sensor_filter: the synchronizer, candidate/stable counter, and sensor_valid generation. It is instanced once in irrigation_sequencer.

Test Plan:
All scenarios use CLK_DIV=4, FILTER_TICKS=2, MIN_RUN_TICKS=3.
1. Reset, then hold h=m=l=1, dry=1, rain=0 → as_valve=1 one cycle after the tick that completes filtering. At the next disp_pulse, level_code=3 and mode_code=2. Check that no valve is open earlier.
2. While in SPRINKLE, drop h to 0 at run_cnt=1 → stays SPRINKLE until run_cnt=3. Then gt_valve=1, as_valve=0, mode_code=3.
3. While in DRIP, set l=m=0 → FILL as soon as filtering completes, without waiting for MIN_RUN. fill_valve=1, level_code=0. Then raise h=m=l=1 → IDLE, all valves 0.
4. Apply h=1, m=0, l=1 → FAULT after filtering, alarm=1, mode_code=4, valves 0, level_code holds its old value. Restore m=1 → IDLE on the next filtered tick.
5. A one-tick glitch on rain during DRIP (shorter than FILTER_TICKS) → no state change. A sustained rain lasting past MIN_RUN → IDLE.
6. Assert reset mid-FILL → fill_valve=0 the next cycle, all codes 0, first disp_pulse no earlier than cycle CLK_DIV+1.
